// File: rtl/ps2_scancode_rx_pkg.sv
// rtl/ps2_scancode_rx_pkg.sv - shared constants, types and helpers for the PS/2 receiver
//
// Purpose: scan-code byte values, prefix encodings, frame FSM state codes,
//          the 11-bit event layout and the frame parity helper.
// Ports:   none (package).
package ps2_scancode_rx_pkg;

    localparam logic [7:0] PS2_PFX_E0 = 8'hE0;
    localparam logic [7:0] PS2_PFX_E1 = 8'hE1;
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'h77;

    localparam logic [1:0] PFX_NONE = 2'b00;
    localparam logic [1:0] PFX_E0   = 2'b01;
    localparam logic [1:0] PFX_E1   = 2'b10;

    localparam int EV_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic [1:0] pfx;
        logic       brk;
        logic [7:0] code;
    } ps2_ev_t;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_sync_fifo.sv
// rtl/ps2_scancode_rx_sync_fifo.sv - reusable synchronous FIFO with count, full and empty
//
// Purpose: single-clock FIFO; head entry is presented combinationally on o_rdata.
// Ports:   clk, rst          clock and synchronous active-high reset
//          i_push, i_wdata   write request and data
//          i_pop             read request (ignored when empty)
//          o_rdata           head entry
//          o_count           number of stored entries
//          o_full, o_empty   occupancy flags
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // A push into a full FIFO is still accepted when the head leaves in the same
    // cycle: the write lands in the slot being vacated.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard receiver with scan-code decoder, event FIFO and history
//
// Purpose: synchronises and filters the PS/2 bus, receives 11-bit frames, checks
//          parity/stop/timeout, folds E0/E1/F0 sequences into make/break events,
//          queues them and keeps a make-code history for the display path.
// Ports:   clk, rst                 clock, synchronous active-high reset
//          kbclk, kbdata            raw asynchronous PS/2 bus
//          ev_valid/ev_ready        event FIFO handshake
//          ev_pfx, ev_brk, ev_code  head event fields (0 while FIFO empty)
//          disp                     make-code history, [7:0] newest
//          rx_busy                  frame FSM not idle
//          err_par, err_frm         one-cycle error pulses
//          overflow                 sticky event-dropped flag
module ps2_scancode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8,
    parameter int HIST_BYTES     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kbclk,
    input  logic                    kbdata,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [1:0]              ev_pfx,
    output logic                    ev_brk,
    output logic [7:0]              ev_code,
    output logic [8*HIST_BYTES-1:0] disp,
    output logic                    rx_busy,
    output logic                    err_par,
    output logic                    err_frm,
    output logic                    overflow
);

    import ps2_scancode_rx_pkg::*;

    localparam int FLT_W = $clog2(FILTER_LEN);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

    // ---------------- synchroniser ----------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   w_clk_s;
    logic                   w_dat_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], kbclk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], kbdata};
        end
    end

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

    // ---------------- glitch filter and strobe ----------------
    logic [FLT_W-1:0] r_flt_cnt;
    logic             r_flt;
    logic             r_flt_q;
    logic             w_strobe;

    // The filtered clock follows the synchronised clock only after FILTER_LEN
    // consecutive samples disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flt_cnt <= '0;
            r_flt     <= 1'b1;
            r_flt_q   <= 1'b1;
        end else begin
            r_flt_q <= r_flt;
            if (w_clk_s == r_flt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_MAX) begin
                r_flt     <= w_clk_s;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_strobe = r_flt_q && !r_flt;

    // ---------------- frame FSM ----------------
    ps2_state_t       r_state;
    ps2_state_t       w_state_nxt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_par;
    logic [TO_W-1:0]  r_to_cnt;
    logic             w_timeout;
    logic             w_frame_end;
    logic             w_par_ok;
    logic             w_stop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: if (w_strobe && !w_dat_s) w_state_nxt = ST_DATA;
            ST_DATA: if (w_strobe && r_bit_cnt == 3'd7) w_state_nxt = ST_PAR;
            ST_PAR:  if (w_strobe) w_state_nxt = ST_STOP;
            ST_STOP: begin
                if (w_strobe) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A strobe arriving on the expiry cycle keeps the frame alive.
        if (r_state != ST_IDLE && !w_strobe && r_to_cnt == TO_MAX) begin
            w_state_nxt = ST_IDLE;
            w_timeout   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (w_strobe) begin
                case (r_state)
                    ST_IDLE: r_bit_cnt <= '0;
                    ST_DATA: begin
                        r_shift   <= {w_dat_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    ST_PAR:  r_par <= w_dat_s;
                    default: ;
                endcase
            end
            if (r_state == ST_IDLE || w_strobe) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign w_par_ok  = odd_parity_ok(r_shift, r_par);
    assign w_stop_ok = w_dat_s;

    // ---------------- frame result register ----------------
    logic       r_byte_vld;
    logic [7:0] r_byte;
    logic       r_err_par;
    logic       r_err_frm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_vld <= 1'b0;
            r_byte     <= '0;
            r_err_par  <= 1'b0;
            r_err_frm  <= 1'b0;
        end else begin
            r_byte_vld <= w_frame_end && w_par_ok && w_stop_ok;
            r_err_par  <= w_frame_end && !w_par_ok;
            r_err_frm  <= (w_frame_end && !w_stop_ok) || w_timeout;
            if (w_frame_end) begin
                r_byte <= r_shift;
            end
        end
    end

    // ---------------- scan-code decoder ----------------
    logic [1:0] r_pfx;
    logic       r_brk;
    logic       r_in_pause;
    logic [2:0] r_pause_cnt;
    logic       w_emit;
    ps2_ev_t    w_ev;

    always_comb begin
        w_emit = 1'b0;
        w_ev   = '0;
        if (r_byte_vld) begin
            if (r_in_pause) begin
                // The seventh swallowed byte completes the pause sequence.
                if (r_pause_cnt == 3'd6) begin
                    w_emit     = 1'b1;
                    w_ev.pfx   = PFX_E1;
                    w_ev.brk   = 1'b0;
                    w_ev.code  = PS2_PAUSE;
                end
            end else if (r_byte != PS2_PFX_E0 && r_byte != PS2_BREAK && r_byte != PS2_PFX_E1) begin
                w_emit    = 1'b1;
                w_ev.pfx  = r_pfx;
                w_ev.brk  = r_brk;
                w_ev.code = r_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pfx       <= PFX_NONE;
            r_brk       <= 1'b0;
            r_in_pause  <= 1'b0;
            r_pause_cnt <= '0;
        end else if (r_byte_vld) begin
            if (r_in_pause) begin
                if (r_pause_cnt == 3'd6) begin
                    r_in_pause <= 1'b0;
                end else begin
                    r_pause_cnt <= r_pause_cnt + 1'b1;
                end
            end else begin
                case (r_byte)
                    PS2_PFX_E0: r_pfx <= PFX_E0;
                    PS2_BREAK:  r_brk <= 1'b1;
                    PS2_PFX_E1: begin
                        r_in_pause  <= 1'b1;
                        r_pause_cnt <= '0;
                        r_pfx       <= PFX_NONE;
                        r_brk       <= 1'b0;
                    end
                    default: begin
                        r_pfx <= PFX_NONE;
                        r_brk <= 1'b0;
                    end
                endcase
            end
        end else if (r_err_par || r_err_frm) begin
            // Errors abandon a pause silently but keep pending E0/F0 flags.
            r_in_pause <= 1'b0;
        end
    end

    // ---------------- event FIFO ----------------
    logic [EV_W-1:0]             w_fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic                        w_pop;
    ps2_ev_t                     w_head;
    logic                        r_overflow;

    assign w_pop = ev_ready && !w_fifo_empty;

    sync_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_emit),
        .i_wdata (w_ev),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_head   = w_fifo_rdata;
    assign ev_valid = (w_fifo_count != '0);
    // Unwritten FIFO storage is never exposed: fields read 0 while empty.
    assign ev_pfx   = ev_valid ? w_head.pfx  : '0;
    assign ev_brk   = ev_valid ? w_head.brk  : 1'b0;
    assign ev_code  = ev_valid ? w_head.code : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_emit && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // ---------------- make-code history ----------------
    logic [8*HIST_BYTES-1:0] r_disp;
    logic [8*HIST_BYTES-1:0] w_disp_nxt;

    if (HIST_BYTES == 1) begin : g_hist1
        always_comb w_disp_nxt = w_ev.code;
    end else begin : g_histn
        always_comb w_disp_nxt = {r_disp[8*HIST_BYTES-9:0], w_ev.code};
    end

    // Updated from the decoder, not the FIFO, so dropped make events still show.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp <= '0;
        end else if (w_emit && !w_ev.brk) begin
            r_disp <= w_disp_nxt;
        end
    end

    assign disp     = r_disp;
    assign rx_busy  = (r_state != ST_IDLE);
    assign err_par  = r_err_par;
    assign err_frm  = r_err_frm;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - self-checking bench for ps2_scancode_rx
module tb_ps2_scancode_rx;

    localparam int TO    = 1000;
    localparam int DEPTH = 8;
    localparam int HP    = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        kbclk;
    logic        kbdata;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_pfx;
    logic        ev_brk;
    logic [7:0]  ev_code;
    logic [15:0] disp;
    logic        rx_busy;
    logic        err_par;
    logic        err_frm;
    logic        overflow;

    ps2_scancode_rx #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH),
        .HIST_BYTES     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .kbclk    (kbclk),
        .kbdata   (kbdata),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_pfx   (ev_pfx),
        .ev_brk   (ev_brk),
        .ev_code  (ev_code),
        .disp     (disp),
        .rx_busy  (rx_busy),
        .err_par  (err_par),
        .err_frm  (err_frm),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_par  = 0;
    int n_frm  = 0;
    int exp_par = 0;
    int exp_frm = 0;

    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];

    // reference model state
    int          m_pause;
    logic [1:0]  m_pfx;
    logic        m_brk;
    logic [15:0] m_disp;

    always @(negedge clk) begin
        if (!rst) begin
            if (ev_valid && ev_ready) got_q.push_back({ev_pfx, ev_brk, ev_code});
            if (err_par) n_par++;
            if (err_frm) n_frm++;
        end
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pause = 0;
        m_pfx   = 2'b00;
        m_brk   = 1'b0;
        m_disp  = '0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic model_emit(input logic [1:0] p, input logic k, input logic [7:0] c);
        exp_q.push_back({p, k, c});
        if (!k) m_disp = {m_disp[7:0], c};
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) model_emit(2'b10, 1'b0, 8'h77);
        end else if (b == 8'hE0) begin
            m_pfx = 2'b01;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            m_pause = 7;
            m_pfx   = 2'b00;
            m_brk   = 1'b0;
        end else begin
            model_emit(m_pfx, m_brk, b);
            m_pfx = 2'b00;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        m_pause = 0;
    endtask

    task automatic ps2_bit(input logic b);
        kbdata = b;
        wait_clk(HP);
        kbclk = 1'b0;
        wait_clk(HP);
        kbclk = 1'b1;
    endtask

    task automatic ps2_frame(input logic [7:0] c, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit((~^c) ^ flip);
        ps2_bit(1'b1);
        kbdata = 1'b1;
        wait_clk(HP);
    endtask

    task automatic send(input logic [7:0] c);
        ps2_frame(c, 1'b0);
        model_byte(c);
    endtask

    task automatic send_bad(input logic [7:0] c);
        ps2_frame(c, 1'b1);
        model_err();
        exp_par++;
    endtask

    task automatic check_events(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check(tag, {ev_valid, ev_pfx, ev_brk, ev_code, disp, rx_busy, err_par, err_frm, overflow}, 32'h0);
    endtask

    initial begin
        logic [7:0] codes[DEPTH+1];
        int k;
        int hold;
        int f0;

        rst = 1'b1;
        kbclk = 1'b1;
        kbdata = 1'b1;
        ev_ready = 1'b0;
        model_reset();
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        check_reset("reset_outputs");

        // 1: single make code, held at the head while not ready
        send(8'h1C);
        k = 0;
        while (!ev_valid && k < 4 * HP) begin wait_clk(1); k++; end
        check("t1_valid", ev_valid, 1);
        wait_clk(7);
        check("t1_head_held", {ev_pfx, ev_brk, ev_code}, {2'b00, 1'b0, 8'h1C});
        check("t1_disp", disp, m_disp);
        ev_ready = 1'b1;
        wait_clk(4);
        check_events("t1_ev");
        check("t1_valid_after_pop", ev_valid, 0);

        // 2: extended break, then a plain make
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("t2_disp_after_break", disp, m_disp);
        send(8'h1C);
        check_events("t2_ev");
        check("t2_disp", disp, m_disp);
        check("t12_err_par", n_par, 0);
        check("t12_err_frm", n_frm, 0);

        // 3: parity error
        send_bad(8'h1C);
        check("t3_err_par", n_par, exp_par);
        check("t3_busy", rx_busy, 0);
        check_events("t3_ev");

        // 4: stall after four data bits
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        kbdata = 1'b1;
        check("t4_busy_during_stall", rx_busy, 1);
        f0 = n_frm;
        k = 0;
        while (n_frm == f0 && k < TO + 300) begin wait_clk(1); k++; end
        exp_frm++;
        model_err();
        check("t4_err_frm", n_frm, exp_frm);
        check("t4_not_early", (k > TO / 2), 1);
        wait_clk(2);
        check("t4_idle", rx_busy, 0);
        send(8'h1C);
        check_events("t4_ev");

        // 5: overflow with ready low
        ev_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            codes[i] = 8'($urandom_range(1, 8'h7F));
            send(codes[i]);
        end
        void'(exp_q.pop_back());
        check("t5_overflow", overflow, 1);
        check("t5_head", ev_code, codes[0]);
        check("t5_disp", disp, m_disp);
        ev_ready = 1'b1;
        wait_clk(DEPTH + 4);
        check_events("t5_ev");
        check("t5_overflow_sticky", overflow, 1);

        // 6: pause sequence
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check_events("t6_pause");
        check("t6_disp", disp, m_disp);

        // 6b: reset in the middle of a frame
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        check("t6_busy_midframe", rx_busy, 1);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        kbdata = 1'b1;
        model_reset();
        wait_clk(2);
        check_reset("t6_reset_midframe");

        // 6c: short glitches on kbclk must not strobe
        kbdata = 1'b0;
        for (int i = 0; i < 5; i++) begin
            kbclk = 1'b0;
            wait_clk(2);
            kbclk = 1'b1;
            wait_clk(30);
        end
        kbdata = 1'b1;
        check("t6_glitch_busy", rx_busy, 0);
        send(8'h1C);
        check_events("t6_after_glitch");

        // randomized byte stream with prefixes and parity errors
        hold = 0;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 8'hE0;
            else if (sel == 1) b = 8'hF0;
            else b = 8'($urandom_range(1, 8'h7F));
            if (hold >= 3) begin ev_ready = 1'b1; hold = 0; end
            else begin ev_ready = 1'($urandom_range(0, 1)); hold = ev_ready ? 0 : hold + 1; end
            if ($urandom_range(0, 7) == 0) send_bad(b);
            else send(b);
        end
        ev_ready = 1'b1;
        wait_clk(DEPTH + 4);
        check_events("rand_ev");
        check("rand_disp", disp, m_disp);
        check("rand_err_par", n_par, exp_par);
        check("rand_err_frm", n_frm, exp_frm);
        check("rand_overflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
